alu_issue_seq: RTL and testbench
================================

ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 instr_valid  input  1  instruction offered this cycle.
REQ-005 instr_ready  output  1  block can accept an instruction.
REQ-006 instr  input  16  [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [8:0] imm9 (LDI only).
REQ-007 alu_in1  output  32  operand A to the external ALU.
REQ-008 alu_in2  output  32  operand B to the external ALU.
REQ-009 alu_control  output  4  ALU op code: 1 and, 2 or, 3 add, 4 sub, 5 slt (signed), 6 nor, 7 xor, other codes give result 0.
REQ-010 alu_out  input  32  combinational ALU result.
REQ-011 alu_zero  input  1  ALU result == 0.
REQ-012 res_valid  output  1  one-cycle completion pulse.
REQ-013 res_data  output  32  completed result.
REQ-014 res_zero  output  1  completed result == 0.
REQ-015 res_err  output  1  completed instruction was illegal.

Function
REQ-016 SHALL contain an 8 x 32-bit register file; r0 reads 0 and ignores writes.
REQ-017 SHALL implement FSM states IDLE, ISSUE, DONE; transitions IDLE->ISSUE on instr_valid&&instr_ready, ISSUE->DONE unconditionally, DONE->IDLE unconditionally.
REQ-018 instr_ready SHALL be 1 only in IDLE; instr_valid outside IDLE is ignored and not queued.
REQ-019 On the accept edge, instr SHALL be latched, and for op 1..7 alu_in1=R[rs], alu_in2=R[rt], alu_control=op, all registered, stable through ISSUE.
REQ-020 At the ISSUE->DONE edge, op 1..7: res_data<=alu_out, res_zero<=alu_zero, res_err<=0, R[rd]<=alu_out.
REQ-021 op 8 (LDI): alu_control SHALL stay 0; at ISSUE->DONE edge res_data<=zero-extended imm9, res_zero<=(imm9==0), res_err<=0, R[rd]<=zero-extended imm9.
REQ-022 op 0 and 9..15 (illegal): no register write; res_data<=0, res_zero<=0, res_err<=1; alu_control stays 0.
REQ-023 res_valid SHALL be 1 exactly in DONE: the cycle after the ISSUE->DONE edge; res_data/res_zero/res_err hold until the next completion.
REQ-024 Latency: accept on edge E0, res_valid high between E1 and E2, instr_ready high again after E2; max throughput one instruction per 3 cycles.
REQ-025 Register writes at E1 SHALL be visible to an instruction accepted at E2 or later (no forwarding required).
REQ-026 alu_control SHALL return to 0 on entry to DONE; alu_in1/alu_in2 hold last values.
REQ-027 rs==rd or rt==rd SHALL read the pre-write value; write occurs only at E1.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, all registers r1..r7 to 0, alu_in1/alu_in2/res_data to 0, alu_control to 0, res_valid/res_zero/res_err to 0, instr_ready to 1 after release.
REQ-029 Reset mid-operation (ISSUE or DONE) SHALL drop the in-flight instruction with no register write and no res_valid pulse.
REQ-030 First accept after reset release SHALL occur on the first clk edge with rst_n high and instr_valid high.

Verification
REQ-031 LDI r1,5; LDI r2,10; AND r3,r1,r2 -> res_data 0, res_zero 1; OR r4,r1,r2 -> 15, res_zero 0, alu_control seen 2 during ISSUE.
REQ-032 SUB r5,r1,r2 -> res_data 0xFFFFFFFB; SLT r6,r5,r1 -> 1; SLT r6,r1,r5 -> 0; NOR r7,r0,r0 -> 0xFFFFFFFF.
REQ-033 LDI r0,7 then OR r3,r0,r0 -> res_data 0, res_zero 1 (r0 unwritten); op 12 -> res_err 1, res_data 0, no register change.
REQ-034 instr_valid held high continuously with 3 instructions -> instr_ready pattern 1,0,0 repeating, res_valid one cycle each, exactly 3 completions, res_valid exactly 2 edges after each accept.
REQ-035 Assert rst_n low during ISSUE of ADD r3,r1,r2 -> no res_valid, r3 reads 0 afterwards, all outputs 0, instr_ready 1 after release.

Source files
------------

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: three-state issue sequencer that takes one 16-bit instruction
// at a time and reads operands from an 8 x 32 register file. It drives an
// external combinational ALU, then writes the result back and reports it with
// a one-cycle completion pulse.
module alu_issue_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] instr,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic [3:0]  alu_control,
   input  logic [31:0] alu_out,
   input  logic        alu_zero,
   output logic        res_valid,
   output logic [31:0] res_data,
   output logic        res_zero,
   output logic        res_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   localparam logic [3:0] OP_LDI = 4'd8;

   state_t            state_q, state_d;
   logic [15:0]       instr_q, instr_d;
   logic [7:0][31:0]  rf_q, rf_d;
   logic [31:0]       alu_in1_q, alu_in1_d;
   logic [31:0]       alu_in2_q, alu_in2_d;
   logic [3:0]        alu_ctl_q, alu_ctl_d;
   logic [31:0]       res_data_q, res_data_d;
   logic              res_zero_q, res_zero_d;
   logic              res_err_q, res_err_d;

   // Fields of the incoming instruction and of the one in flight
   logic [3:0] in_op;
   logic [3:0] op_q;
   logic [2:0] rd_q;
   logic [8:0] imm9_q;
   logic       in_is_alu, q_is_alu;

   assign in_op     = instr[15:12];
   assign op_q      = instr_q[15:12];
   assign rd_q      = instr_q[11:9];
   assign imm9_q    = instr_q[8:0];
   assign in_is_alu = (in_op >= 4'd1) && (in_op <= 4'd7);
   assign q_is_alu  = (op_q  >= 4'd1) && (op_q  <= 4'd7);

   // Next-state, operand capture and writeback; every register holds by default
   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      rf_d       = rf_q;
      alu_in1_d  = alu_in1_q;
      alu_in2_d  = alu_in2_q;
      alu_ctl_d  = alu_ctl_q;
      res_data_d = res_data_q;
      res_zero_d = res_zero_q;
      res_err_d  = res_err_q;
      case (state_q)
         IDLE: begin
            if (instr_valid) begin
               state_d = ISSUE;
               instr_d = instr;
               if (in_is_alu) begin
                  // Reads here see the file before the writeback at the end of ISSUE
                  alu_in1_d = rf_q[instr[8:6]];
                  alu_in2_d = rf_q[instr[5:3]];
                  alu_ctl_d = in_op;
               end else begin
                  alu_ctl_d = 4'd0;
               end
            end
         end
         ISSUE: begin
            state_d   = DONE;
            alu_ctl_d = 4'd0;
            if (q_is_alu) begin
               res_data_d = alu_out;
               res_zero_d = alu_zero;
               res_err_d  = 1'b0;
               if (rd_q != 3'd0) rf_d[rd_q] = alu_out;
            end else if (op_q == OP_LDI) begin
               res_data_d = {23'd0, imm9_q};
               res_zero_d = (imm9_q == 9'd0);
               res_err_d  = 1'b0;
               if (rd_q != 3'd0) rf_d[rd_q] = {23'd0, imm9_q};
            end else begin
               res_data_d = 32'd0;
               res_zero_d = 1'b0;
               res_err_d  = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      rf_d[0] = 32'd0;
   end

   // State and datapath registers; reset drops any in-flight instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         instr_q    <= '0;
         rf_q       <= '0;
         alu_in1_q  <= '0;
         alu_in2_q  <= '0;
         alu_ctl_q  <= '0;
         res_data_q <= '0;
         res_zero_q <= 1'b0;
         res_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         rf_q       <= rf_d;
         alu_in1_q  <= alu_in1_d;
         alu_in2_q  <= alu_in2_d;
         alu_ctl_q  <= alu_ctl_d;
         res_data_q <= res_data_d;
         res_zero_q <= res_zero_d;
         res_err_q  <= res_err_d;
      end
   end

   assign instr_ready = (state_q == IDLE);
   assign res_valid   = (state_q == DONE);
   assign alu_in1     = alu_in1_q;
   assign alu_in2     = alu_in2_q;
   assign alu_control = alu_ctl_q;
   assign res_data    = res_data_q;
   assign res_zero    = res_zero_q;
   assign res_err     = res_err_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: provides a behavioural ALU and drives a vector table
// of instructions with hand-computed results. It then runs back-to-back issue
// and mid-flight reset sequences. Expected results go into a queue at drive
// time and are popped when res_valid fires.
module tb_alu_issue_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = '0;
   logic [31:0] alu_in1, alu_in2, alu_out;
   logic [3:0]  alu_control;
   logic        alu_zero;
   logic        res_valid, res_zero, res_err;
   logic [31:0] res_data;

   int nchk = 0;
   int nerr = 0;
   int ncomp = 0;

   typedef struct {
      logic [31:0] data;
      logic        zero;
      logic        err;
   } exp_t;

   typedef struct {
      logic [15:0] ins;
      logic [31:0] data;
      logic        zero;
      logic        err;
   } vec_t;

   exp_t q[$];
   vec_t tbl[16];

   alu_issue_seq dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
      .alu_out(alu_out), .alu_zero(alu_zero), .res_valid(res_valid), .res_data(res_data),
      .res_zero(res_zero), .res_err(res_err)
   );

   always #5 clk = ~clk;

   // External ALU
   always_comb begin
      alu_out = 32'd0;
      case (alu_control)
         4'd1: alu_out = alu_in1 & alu_in2;
         4'd2: alu_out = alu_in1 | alu_in2;
         4'd3: alu_out = alu_in1 + alu_in2;
         4'd4: alu_out = alu_in1 - alu_in2;
         4'd5: alu_out = ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
         4'd6: alu_out = ~(alu_in1 | alu_in2);
         4'd7: alu_out = alu_in1 ^ alu_in2;
         default: alu_out = 32'd0;
      endcase
   end
   assign alu_zero = (alu_out == 32'd0);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Completion monitor: every res_valid must match the oldest expectation
   always @(negedge clk) begin
      if (res_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_res_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            ncomp++;
            chk("res_data", res_data, e.data);
            chk("res_zero", {31'd0, res_zero}, {31'd0, e.zero});
            chk("res_err",  {31'd0, res_err},  {31'd0, e.err});
         end
      end
   end

   // Offer one instruction and check the ALU opcode seen during ISSUE
   task automatic issue(input logic [15:0] ins, input logic [31:0] d, input logic z,
                        input logic e, input bit push);
      int n;
      logic [3:0] op;
      exp_t x;
      n = 0;
      @(negedge clk);
      while (!instr_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) begin
         chk("ready_timeout", 32'd0, 32'd1);
      end else begin
         instr_valid = 1'b1;
         instr = ins;
         if (push) begin
            x.data = d; x.zero = z; x.err = e;
            q.push_back(x);
         end
         @(posedge clk);
         #1;
         instr_valid = 1'b0;
         op = ins[15:12];
         chk("alu_control_issue", {28'd0, alu_control},
             (op >= 4'd1 && op <= 4'd7) ? {28'd0, op} : 32'd0);
         chk("ready_low_issue", {31'd0, instr_ready}, 32'd0);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      while ((q.size() != 0 || !instr_ready) && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue_empty", q.size(), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_alu_in1"}, alu_in1, 32'd0);
      chk({tag, "_alu_in2"}, alu_in2, 32'd0);
      chk({tag, "_alu_ctl"}, {28'd0, alu_control}, 32'd0);
      chk({tag, "_res_data"}, res_data, 32'd0);
      chk({tag, "_res_flags"}, {29'd0, res_valid, res_zero, res_err}, 32'd0);
   endtask

   initial begin
      int c0;
      exp_t x;
      vec_t b2b[3];

      tbl[0]  = '{16'h8205, 32'd5,          1'b0, 1'b0}; // LDI r1,5
      tbl[1]  = '{16'h840A, 32'd10,         1'b0, 1'b0}; // LDI r2,10
      tbl[2]  = '{16'h1650, 32'd0,          1'b1, 1'b0}; // AND r3,r1,r2
      tbl[3]  = '{16'h2850, 32'd15,         1'b0, 1'b0}; // OR  r4,r1,r2
      tbl[4]  = '{16'h4A50, 32'hFFFFFFFB,   1'b0, 1'b0}; // SUB r5,r1,r2
      tbl[5]  = '{16'h5D48, 32'd1,          1'b0, 1'b0}; // SLT r6,r5,r1
      tbl[6]  = '{16'h5C68, 32'd0,          1'b1, 1'b0}; // SLT r6,r1,r5
      tbl[7]  = '{16'h6E00, 32'hFFFFFFFF,   1'b0, 1'b0}; // NOR r7,r0,r0
      tbl[8]  = '{16'h8007, 32'd7,          1'b0, 1'b0}; // LDI r0,7
      tbl[9]  = '{16'h2600, 32'd0,          1'b1, 1'b0}; // OR  r3,r0,r0
      tbl[10] = '{16'hCE50, 32'd0,          1'b0, 1'b1}; // op 12, rd=r7
      tbl[11] = '{16'h37C0, 32'hFFFFFFFF,   1'b0, 1'b0}; // ADD r3,r7,r0
      tbl[12] = '{16'h3490, 32'd20,         1'b0, 1'b0}; // ADD r2,r2,r2
      tbl[13] = '{16'h7888, 32'd17,         1'b0, 1'b0}; // XOR r4,r2,r1
      tbl[14] = '{16'h0000, 32'd0,          1'b0, 1'b1}; // op 0
      tbl[15] = '{16'hF000, 32'd0,          1'b0, 1'b1}; // op 15

      // Reset state
      #12;
      chk_all_zero("reset");
      chk("reset_ready", {31'd0, instr_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++)
         issue(tbl[i].ins, tbl[i].data, tbl[i].zero, tbl[i].err, 1'b1);
      drain();
      chk("res_hold_err", {31'd0, res_err}, 32'd1);

      // Back-to-back: instr_valid held high across three instructions
      b2b[0] = '{16'h8203, 32'd3, 1'b0, 1'b0}; // LDI r1,3
      b2b[1] = '{16'h8404, 32'd4, 1'b0, 1'b0}; // LDI r2,4
      b2b[2] = '{16'h3650, 32'd7, 1'b0, 1'b0}; // ADD r3,r1,r2
      c0 = ncomp;
      instr_valid = 1'b1;
      for (int k = 0; k < 9; k++) begin
         chk("b2b_ready", {31'd0, instr_ready}, (k % 3 == 0) ? 32'd1 : 32'd0);
         chk("b2b_res_valid", {31'd0, res_valid}, (k % 3 == 2) ? 32'd1 : 32'd0);
         if (k % 3 == 0) begin
            instr = b2b[k / 3].ins;
            x.data = b2b[k / 3].data; x.zero = b2b[k / 3].zero; x.err = b2b[k / 3].err;
            q.push_back(x);
         end
         @(negedge clk);
      end
      instr_valid = 1'b0;
      chk("b2b_completions", ncomp - c0, 32'd3);
      drain();

      // Reset during ISSUE of ADD r3,r1,r2: dropped, no writeback
      issue(16'h3650, 32'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_ready", {31'd0, instr_ready}, 32'd1);
      // First edge after release accepts; r3 and r1 must read 0
      issue(16'h28C8, 32'd0, 1'b1, 1'b0, 1'b1); // OR r4,r3,r1
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
